mmul_a_seq_ctrl: RTL and testbench

//  Sequencer for the 256-bit operand-A shift register of the Montgomery multiplier.

---
 rtl/mmul_a_seq_ctrl_pkg.sv | 24 ++
 rtl/mmul_a_seq_ctrl_if.sv | 26 ++
 rtl/mmul_a_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mmul_a_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_a_seq_ctrl_pkg.sv
// Shared constants and types for the operand-A sequencer of the Montgomery multiplier.
// Holds operand geometry, state encoding and the register-control bundle.
package mmul_a_seq_ctrl_pkg;

  localparam int MMUL_WORD_W = 16;
  localparam int MMUL_NWORDS = 16;
  localparam int MMUL_NBITS  = MMUL_WORD_W * MMUL_NWORDS;
  localparam int MMUL_WCNT_W = $clog2(MMUL_NWORDS);
  localparam int MMUL_BCNT_W = $clog2(MMUL_NBITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mmul_state_e;

  // Controls for the external A shift register: sel=0 shift 16 in, sel=1 shift 1 out
  typedef struct packed {
    logic we;
    logic sel;
  } mmul_reg_ctl_t;

endpackage

// File: rtl/mmul_a_seq_ctrl_if.sv
// Word-load stream, bit-serial stream and register-control bundle of the A sequencer.
// slave = the sequencer; master = loader/datapath/register side.
interface mmul_a_seq_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              bit_valid;
  logic              bit_ack;
  logic [IDX_W-1:0]  bit_idx;
  logic              reg_we;
  logic              reg_sel;
  logic [WORD_W-1:0] reg_din;

  modport slave (
    input  word_in, word_valid, bit_ack,
    output word_ready, bit_valid, bit_idx, reg_we, reg_sel, reg_din
  );

  modport master (
    output word_in, word_valid, bit_ack,
    input  word_ready, bit_valid, bit_idx, reg_we, reg_sel, reg_din
  );
endinterface

// File: rtl/mmul_a_seq_ctrl.sv
// Operand-A sequencer: loads NWORDS words into the external shift register, then
// steps it right one bit per datapath acknowledge, exposing bit index and a done pulse.
module mmul_a_seq_ctrl
  import mmul_a_seq_ctrl_pkg::*;
#(
  parameter int WORD_W = MMUL_WORD_W,
  parameter int NWORDS = MMUL_NWORDS,
  parameter int NBITS  = MMUL_NBITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  mmul_a_seq_ctrl_if.slave   a_if,
  output logic               busy,
  output logic               done
);

  localparam int WCNT_W = $clog2(NWORDS);
  localparam int BCNT_W = $clog2(NBITS);

  mmul_state_e       state, state_nxt;
  logic [WCNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic              word_ready, bit_valid, done_c;
  mmul_reg_ctl_t     rctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  // Handshake outputs are suppressed under rst or abort so no register write can leak
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    bit_cnt_nxt  = bit_cnt;
    word_ready   = 1'b0;
    bit_valid    = 1'b0;
    done_c       = 1'b0;
    rctl         = '0;
    if (!rst && abort) begin
      state_nxt    = ST_IDLE;
      word_cnt_nxt = '0;
      bit_cnt_nxt  = '0;
    end else if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt    = ST_LOAD;
            word_cnt_nxt = '0;
          end
        end
        ST_LOAD: begin
          word_ready = 1'b1;
          if (a_if.word_valid) begin
            rctl.we      = 1'b1;
            rctl.sel     = 1'b0;
            word_cnt_nxt = word_cnt + WCNT_W'(1);
            if (word_cnt == WCNT_W'(NWORDS - 1)) begin
              state_nxt    = ST_RUN;
              word_cnt_nxt = '0;
              bit_cnt_nxt  = '0;
            end
          end
        end
        ST_RUN: begin
          bit_valid = 1'b1;
          if (a_if.bit_ack) begin
            rctl.we     = 1'b1;
            rctl.sel    = 1'b1;
            bit_cnt_nxt = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(NBITS - 1)) begin
              state_nxt   = ST_DONE;
              bit_cnt_nxt = '0;
            end
          end
        end
        ST_DONE: begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign a_if.word_ready = word_ready;
  assign a_if.bit_valid  = bit_valid;
  assign a_if.bit_idx    = bit_valid ? bit_cnt : '0;
  assign a_if.reg_we     = rctl.we;
  assign a_if.reg_sel    = rctl.sel;
  assign a_if.reg_din    = WORD_W'(a_if.word_in);
  assign busy            = !rst && (state == ST_LOAD || state == ST_RUN);
  assign done            = done_c;

endmodule

// File: tb/tb_mmul_a_seq_ctrl.sv
// Randomized bench for mmul_a_seq_ctrl: a transaction-level model of word/bit
// consumption plus a model of the external A shift register driven by reg_*.
module tb_mmul_a_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done;

  mmul_a_seq_ctrl_if #(.WORD_W(16), .IDX_W(8)) a_if ();

  mmul_a_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a_if  (a_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_RUN = 2, MD_DONE = 3;

  int n_chk = 0, n_err = 0;

  // Model: phase plus how many words / bits have been consumed so far
  int           m_mode = MD_IDLE, m_nw = 0, m_nb = 0;
  logic [255:0] m_a = '0;
  logic [255:0] rmodel = '0;
  int           cyc = 0, first_bv = 0, last_done = 0, n_done = 0;
  bit           bv_seen = 1'b0;

  logic        s_rst = 1'b1, s_start = 1'b0, s_abort = 1'b0, s_wv = 1'b0, s_ack = 1'b0;
  logic [15:0] s_win = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic       e_rdy, e_bv, e_we, e_sel, e_busy, e_done;
    logic [7:0] e_idx;
    logic       d_we, d_sel;
    logic [15:0] d_din;
    @(negedge clk);
    rst             = s_rst;
    start           = s_start;
    abort           = s_abort;
    a_if.word_valid = s_wv;
    a_if.word_in    = s_win;
    a_if.bit_ack    = s_ack;
    #1;
    e_rdy  = !s_rst && !s_abort && (m_mode == MD_LOAD);
    e_bv   = !s_rst && !s_abort && (m_mode == MD_RUN);
    e_idx  = e_bv ? m_nb[7:0] : 8'd0;
    e_we   = (e_rdy && s_wv) || (e_bv && s_ack);
    e_sel  = e_bv && s_ack;
    e_busy = !s_rst && (m_mode == MD_LOAD || m_mode == MD_RUN);
    e_done = !s_rst && !s_abort && (m_mode == MD_DONE);
    chk("word_ready", a_if.word_ready, e_rdy);
    chk("bit_valid", a_if.bit_valid, e_bv);
    chk("bit_idx", a_if.bit_idx, e_idx);
    chk("reg_we", a_if.reg_we, e_we);
    chk("reg_sel", a_if.reg_sel, e_sel);
    chk("reg_din", a_if.reg_din, s_win);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (e_bv) begin
      chk("a_lsb", rmodel[0], m_a[m_nb]);
      if (m_nb == 0 && !bv_seen) begin
        first_bv = cyc;
        bv_seen  = 1'b1;
      end
    end
    if (done === 1'b1) begin
      n_done++;
      last_done = cyc;
    end
    d_we  = a_if.reg_we;
    d_sel = a_if.reg_sel;
    d_din = a_if.reg_din;
    @(posedge clk);
    if (d_we === 1'b1)
      rmodel = d_sel ? {1'b0, rmodel[255:1]} : {d_din, rmodel[255:16]};
    if (s_rst || s_abort) begin
      m_mode = MD_IDLE; m_nw = 0; m_nb = 0;
    end else begin
      case (m_mode)
        MD_IDLE: if (s_start) begin m_mode = MD_LOAD; m_nw = 0; end
        MD_LOAD: if (s_wv) begin
          m_a[16*m_nw +: 16] = s_win;
          m_nw++;
          if (m_nw == 16) begin m_mode = MD_RUN; m_nb = 0; bv_seen = 1'b0; end
        end
        MD_RUN: if (s_ack) begin
          m_nb++;
          if (m_nb == 256) m_mode = MD_DONE;
        end
        default: m_mode = MD_IDLE;
      endcase
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    s_rst = 0; s_start = 0; s_abort = 0; s_wv = 0; s_ack = 0;
    repeat (n) step();
  endtask

  task automatic do_load(input logic [255:0] a, input int vprob, input int stall_at, input int stall_len);
    int g = 0, st = 0;
    s_start = 1; step(); s_start = 0;
    while (m_mode == MD_LOAD && g < 1000) begin
      s_wv = ($urandom_range(99) < vprob);
      if (m_nw == stall_at && st < stall_len) begin s_wv = 0; st++; end
      s_win = s_wv ? a[16*m_nw +: 16] : 16'($urandom);
      step(); g++;
    end
    s_wv = 0;
    chk("load_in_budget", g < 1000, 1'b1);
  endtask

  task automatic do_run(input int aprob, input int every, input int stop_at, input int sprob);
    int g = 0, k = 0;
    while (m_mode == MD_RUN && g < 5000 && !(stop_at >= 0 && m_nb == stop_at)) begin
      s_ack   = (every > 0) ? (k % every == every - 1) : ($urandom_range(99) < aprob);
      s_start = ($urandom_range(99) < sprob);
      k++;
      step(); g++;
    end
    s_ack = 0; s_start = 0;
    chk("run_in_budget", g < 5000, 1'b1);
  endtask

  function automatic logic [255:0] rand_a();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] a;
    // Reset, including a reset cycle with active handshake inputs
    s_rst = 1; step();
    s_wv = 1; s_ack = 1; s_start = 1; step();
    idle(2);

    // 1: words 1..16 back-to-back
    for (int i = 0; i < 16; i++) a[16*i +: 16] = 16'(i + 1);
    do_load(a, 100, -1, 0);
    chk("t1_reg_image", rmodel, a);
    do_run(100, 0, -1, 0);
    idle(2);

    // 2: A=1, ack every cycle; done lands 256 cycles after the first bit_valid
    a = 256'd1; n_done = 0;
    do_load(a, 100, -1, 0);
    do_run(100, 0, -1, 0);
    idle(3);
    chk("t2_done_count", n_done, 1);
    chk("t2_done_latency", last_done - first_bv, 256);

    // 3: all-ones, ack every third cycle
    a = '1; n_done = 0;
    do_load(a, 100, -1, 0);
    do_run(0, 3, -1, 0);
    idle(3);
    chk("t3_done_count", n_done, 1);

    // 4: five-cycle valid stall after word 7
    a = rand_a();
    do_load(a, 100, 8, 5);
    chk("t4_reg_image", rmodel, a);
    do_run(60, 0, -1, 0);
    idle(2);

    // 5: abort at bit 100, abort in LOAD and DONE, reset mid-load, then fresh run
    n_done = 0;
    do_load(rand_a(), 70, -1, 0);
    do_run(80, 0, 100, 0);
    s_abort = 1; s_ack = 1; step();
    idle(3);
    s_abort = 1; s_start = 1; step();
    idle(2);
    s_start = 1; step(); s_start = 0;
    s_wv = 1; s_win = 16'h1234; step(); step();
    s_abort = 1; step();
    idle(2);
    do_load(rand_a(), 90, -1, 0);
    do_run(100, 0, -1, 0);
    s_abort = 1; step();
    idle(2);
    chk("t5_no_done", n_done, 0);
    s_start = 1; step(); s_start = 0;
    s_wv = 1;
    repeat (5) begin s_win = 16'($urandom); step(); end
    s_rst = 1; s_ack = 1; step();
    idle(2);
    do_load(rand_a(), 50, -1, 0);
    do_run(50, 0, -1, 0);
    idle(2);
    chk("t5_fresh_done", n_done, 1);

    // 6: start during RUN/DONE, ack and valid in IDLE
    n_done = 0;
    do_load(rand_a(), 100, -1, 0);
    do_run(100, 0, -1, 30);
    s_start = 1; step();
    s_start = 0; s_ack = 1; s_wv = 1;
    repeat (4) begin s_win = 16'($urandom); step(); end
    idle(2);
    chk("t6_done_count", n_done, 1);

    // Random loads and runs
    n_done = 0;
    repeat (4) begin
      do_load(rand_a(), $urandom_range(30, 100), -1, 0);
      do_run($urandom_range(30, 100), 0, -1, 10);
      idle($urandom_range(1, 3));
    end
    chk("rand_done_count", n_done, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
